// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard control for the RV32IM EX stage.
//
// Keeps {rd, we, ld} for the instructions in EX, MEM and WB. For the instruction
// currently in ID it works out the 2-bit operand-mux selects, and registers them
// into fwd_sel_a / fwd_sel_b on the edge where that instruction moves into EX.
// When a load sitting in EX feeds the ID instruction, it raises stall_out
// (combinational) for one cycle and puts a bubble into EX.
//
// Select encoding:
//   2'b00 register-file value from ID/EX
//   2'b01 EX/MEM ALU result
//   2'b10 MEM/WB result
//   2'b11 last-writeback holding register
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   id_rs1, id_rs2               source register addresses in ID
//   id_rs1_used, id_rs2_used     the ID instruction reads that source
//   id_rd, id_reg_write          destination register and write enable in ID
//   id_mem_read                  the ID instruction is a load
//   stall_in                     external freeze; everything holds
//   flush                        flush of the ID instruction
//   fwd_sel_a, fwd_sel_b         registered operand selects for EX
//   stall_out                    hold PC and IF/ID (combinational)
//
// Optional feature (macro FWD_HAZARD_PERF_EN):
//   lu_stall_cnt   counts cycles in which stall_out is high
//   fwd_cnt        counts advances of an EX instruction that uses a forward
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              stall_in,
    input  logic              flush,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic              stall_out
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

    // Sources of the next state on a clock edge
    typedef enum logic [1:0] {
        UPD_HOLD   = 2'b00,
        UPD_BUBBLE = 2'b01,
        UPD_ISSUE  = 2'b10
    } upd_e;

    // Pipeline entries
    logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
    logic              ex_we_q,  ex_we_d;
    logic              ex_ld_q,  ex_ld_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_ld_q, mem_ld_d;
    logic [REG_AW-1:0] wb_rd_q,  wb_rd_d;
    logic              wb_we_q,  wb_we_d;
    logic              wb_ld_q,  wb_ld_d;

    logic [SEL_W-1:0]  fwd_sel_a_q, fwd_sel_a_d;
    logic [SEL_W-1:0]  fwd_sel_b_q, fwd_sel_b_d;

    logic [SEL_W-1:0]  sel_a_s;
    logic [SEL_W-1:0]  sel_b_s;
    logic              load_use_s;
    upd_e              upd_s;

    // Picks the youngest in-flight producer of rs. x0 and unread sources always
    // select the register file.
    function automatic logic [SEL_W-1:0] calc_sel(
        input logic [REG_AW-1:0] rs,
        input logic              used,
        input logic [REG_AW-1:0] e_rd,
        input logic              e_we,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_RF;
        if (!used || (rs == REG_X0)) begin
            sel = SEL_RF;
        end else if (e_we && (e_rd == rs)) begin
            sel = SEL_EX;
        end else if (m_we && (m_rd == rs)) begin
            sel = SEL_MEM;
        end else if (w_we && (w_rd == rs)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Operand selects for the instruction in ID
    always_comb begin
        sel_a_s = calc_sel(id_rs1, id_rs1_used, ex_rd_q, ex_we_q,
                           mem_rd_q, mem_we_q, wb_rd_q, wb_we_q);
        sel_b_s = calc_sel(id_rs2, id_rs2_used, ex_rd_q, ex_we_q,
                           mem_rd_q, mem_we_q, wb_rd_q, wb_we_q);
    end

    // Load in EX whose result the ID instruction needs; an external freeze
    // masks it so that the ID instruction does not also see a hazard stall
    always_comb begin
        load_use_s = ex_ld_q && ex_we_q && (ex_rd_q != REG_X0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                      (id_rs2_used && (id_rs2 == ex_rd_q))) &&
                     !stall_in;
    end

    // Choose the update: the freeze wins, and both flush and load-use put a bubble in EX
    always_comb begin
        if (stall_in) begin
            upd_s = UPD_HOLD;
        end else if (flush || load_use_s) begin
            upd_s = UPD_BUBBLE;
        end else begin
            upd_s = UPD_ISSUE;
        end
    end

    // Next-state of entries and selects
    always_comb begin
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_ld_d     = ex_ld_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        mem_ld_d    = mem_ld_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        wb_ld_d     = wb_ld_q;
        fwd_sel_a_d = fwd_sel_a_q;
        fwd_sel_b_d = fwd_sel_b_q;
        case (upd_s)
            UPD_HOLD: begin
                ex_rd_d     = ex_rd_q;
                fwd_sel_a_d = fwd_sel_a_q;
                fwd_sel_b_d = fwd_sel_b_q;
            end
            UPD_BUBBLE: begin
                wb_rd_d     = mem_rd_q;
                wb_we_d     = mem_we_q;
                wb_ld_d     = mem_ld_q;
                mem_rd_d    = ex_rd_q;
                mem_we_d    = ex_we_q;
                mem_ld_d    = ex_ld_q;
                ex_rd_d     = REG_X0;
                ex_we_d     = 1'b0;
                ex_ld_d     = 1'b0;
                fwd_sel_a_d = SEL_RF;
                fwd_sel_b_d = SEL_RF;
            end
            UPD_ISSUE: begin
                wb_rd_d     = mem_rd_q;
                wb_we_d     = mem_we_q;
                wb_ld_d     = mem_ld_q;
                mem_rd_d    = ex_rd_q;
                mem_we_d    = ex_we_q;
                mem_ld_d    = ex_ld_q;
                ex_rd_d     = id_rd;
                ex_we_d     = id_reg_write;
                ex_ld_d     = id_mem_read;
                fwd_sel_a_d = sel_a_s;
                fwd_sel_b_d = sel_b_s;
            end
            default: begin
                ex_rd_d     = REG_X0;
                ex_we_d     = 1'b0;
                ex_ld_d     = 1'b0;
                mem_rd_d    = REG_X0;
                mem_we_d    = 1'b0;
                mem_ld_d    = 1'b0;
                wb_rd_d     = REG_X0;
                wb_we_d     = 1'b0;
                wb_ld_d     = 1'b0;
                fwd_sel_a_d = SEL_RF;
                fwd_sel_b_d = SEL_RF;
            end
        endcase
    end

    // State registers; reset turns every entry into a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_q     <= REG_X0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_rd_q    <= REG_X0;
            mem_we_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            wb_rd_q     <= REG_X0;
            wb_we_q     <= 1'b0;
            wb_ld_q     <= 1'b0;
            fwd_sel_a_q <= SEL_RF;
            fwd_sel_b_q <= SEL_RF;
        end else begin
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_ld_q    <= mem_ld_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            wb_ld_q     <= wb_ld_d;
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
        end
    end

    // Output mapping
    always_comb begin
        fwd_sel_a = fwd_sel_a_q;
        fwd_sel_b = fwd_sel_b_q;
        stall_out = load_use_s;
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [31:0] fwd_cnt_q,      fwd_cnt_d;

    // Counters wrap naturally. load_use_s is already low during a freeze, and
    // the forward count needs an advance, so both counters hold under stall_in.
    always_comb begin
        lu_stall_cnt_d = lu_stall_cnt_q;
        fwd_cnt_d      = fwd_cnt_q;
        if (load_use_s) begin
            lu_stall_cnt_d = lu_stall_cnt_q + 32'd1;
        end else begin
            lu_stall_cnt_d = lu_stall_cnt_q;
        end
        if (!stall_in && ((fwd_sel_a_q != SEL_RF) || (fwd_sel_b_q != SEL_RF))) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt_q <= 32'd0;
            fwd_cnt_q      <= 32'd0;
        end else begin
            lu_stall_cnt_q <= lu_stall_cnt_d;
            fwd_cnt_q      <= fwd_cnt_d;
        end
    end

    // Counter outputs
    always_comb begin
        lu_stall_cnt = lu_stall_cnt_q;
        fwd_cnt      = fwd_cnt_q;
    end
`endif

endmodule
